// File: rtl/core_share_arb_pkg.sv
// Shared types for the core-sharing arbiter: FSM state encoding and stats counter widths.
package core_share_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_FWD  = 1'b1
  } core_arb_state_t;

  localparam int GRANT_CNT_W  = 32;
  localparam int ORPHAN_CNT_W = 16;

endpackage

// File: rtl/core_share_arb_if.sv
// AXI-stream style packet bus: one word per val&&rdy handshake, sop/eop framing, mod = valid bytes on eop.
interface core_share_arb_if #(
  parameter int DAT_BYTS = 8,
  parameter int CTL_BITS = 8
) ();
  localparam int MOD_BITS = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1;

  logic [DAT_BYTS*8-1:0] dat;
  logic                  val;
  logic                  sop;
  logic                  eop;
  logic [MOD_BITS-1:0]   mod;
  logic                  err;
  logic [CTL_BITS-1:0]   ctl;
  logic                  rdy;

  modport master (output dat, val, sop, eop, mod, err, ctl, input rdy);
  modport slave  (input dat, val, sop, eop, mod, err, ctl, output rdy);
endinterface

// File: rtl/core_share_arb_tag_fifo.sv
// Tag FIFO remembering which requester owns each packet in flight at the core (reply order == request order).
module core_share_arb_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_tag,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_tag,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_empty_nxt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push, pop;

  assign o_full      = (cnt_q == CW'(DEPTH));
  assign o_empty     = (cnt_q == '0);
  assign push        = i_push && !o_full;
  assign pop         = i_pop && !o_empty;
  assign o_tag       = mem_q[rd_q];
  assign o_empty_nxt = (cnt_d == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_q] <= i_tag;
  end
endmodule

// File: rtl/core_share_arb.sv
// Packet-level round-robin sharing of one in-order core between NUM_REQ streams; replies return to their originator.
// Optional CORE_SHARE_ARB_STATS_EN adds saturating per-requester grant counts and an orphan-word count.
module core_share_arb
  import core_share_arb_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int DAT_BYTS        = 8,
  parameter int CTL_BITS        = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  core_share_arb_if.slave  i_req [NUM_REQ],
  core_share_arb_if.master o_core,
  core_share_arb_if.slave  i_core_rpl,
  core_share_arb_if.master o_rpl [NUM_REQ],
  output logic            o_orphan,
  output logic            o_busy
`ifdef CORE_SHARE_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][GRANT_CNT_W-1:0] o_grant_cnt,
  output logic [ORPHAN_CNT_W-1:0]             o_orphan_cnt
`endif
);
  localparam int DW = DAT_BYTS * 8;
  localparam int MW = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1;
  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0][DW-1:0]       req_dat;
  logic [NUM_REQ-1:0][MW-1:0]       req_mod;
  logic [NUM_REQ-1:0][CTL_BITS-1:0] req_ctl;
  logic [NUM_REQ-1:0]               req_val, req_sop, req_eop, req_err, req_rdy;
  logic [NUM_REQ-1:0]               rpl_val, rpl_rdy;

  core_arb_state_t state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d, last_q, last_d, cand, sel, head;
  logic            found, core_val, push, pop, crpl_rdy, orphan;
  logic            fifo_full, fifo_empty, fifo_empty_nxt, busy_q;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign req_dat[i]    = i_req[i].dat;
    assign req_val[i]    = i_req[i].val;
    assign req_sop[i]    = i_req[i].sop;
    assign req_eop[i]    = i_req[i].eop;
    assign req_mod[i]    = i_req[i].mod;
    assign req_err[i]    = i_req[i].err;
    assign req_ctl[i]    = i_req[i].ctl;
    assign i_req[i].rdy  = req_rdy[i];

    assign o_rpl[i].dat  = i_core_rpl.dat;
    assign o_rpl[i].sop  = i_core_rpl.sop;
    assign o_rpl[i].eop  = i_core_rpl.eop;
    assign o_rpl[i].mod  = i_core_rpl.mod;
    assign o_rpl[i].err  = i_core_rpl.err;
    assign o_rpl[i].ctl  = i_core_rpl.ctl;
    assign o_rpl[i].val  = rpl_val[i];
    assign rpl_rdy[i]    = o_rpl[i].rdy;
  end

  assign o_core.dat = req_dat[grant_q];
  assign o_core.sop = req_sop[grant_q];
  assign o_core.eop = req_eop[grant_q];
  assign o_core.mod = req_mod[grant_q];
  assign o_core.err = req_err[grant_q];
  assign o_core.ctl = req_ctl[grant_q];
  assign o_core.val = core_val;

  // Request side: pick in IDLE, forward the whole packet in FWD.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    req_rdy  = '0;
    core_val = 1'b0;
    push     = 1'b0;
    cand     = '0;
    sel      = '0;
    found    = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          cand = GW'((int'(last_q) + k) % NUM_REQ);
          if (!found && req_val[cand] && req_sop[cand]) begin
            found = 1'b1;
            sel   = cand;
          end
        end
        // Stray mid-packet words with no grant are flushed so they cannot block.
        for (int i = 0; i < NUM_REQ; i++)
          if (req_val[i] && !req_sop[i]) req_rdy[i] = 1'b1;
        if (found && !fifo_full) begin
          state_d = ARB_FWD;
          grant_d = sel;
        end
      end
      ARB_FWD: begin
        core_val         = req_val[grant_q];
        req_rdy[grant_q] = o_core.rdy;
        if (core_val && o_core.rdy && req_eop[grant_q]) begin
          push    = 1'b1;
          last_d  = grant_q;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    if (i_rst) begin
      req_rdy  = '0;
      core_val = 1'b0;
      push     = 1'b0;
    end
  end

  // Reply side: route to the oldest outstanding tag, or drop when nothing is outstanding.
  always_comb begin
    rpl_val  = '0;
    crpl_rdy = 1'b0;
    orphan   = 1'b0;
    pop      = 1'b0;
    if (!i_rst) begin
      if (fifo_empty) begin
        crpl_rdy = i_core_rpl.val;
        orphan   = i_core_rpl.val;
      end else begin
        rpl_val[head] = i_core_rpl.val;
        crpl_rdy      = rpl_rdy[head];
        pop           = i_core_rpl.val && rpl_rdy[head] && i_core_rpl.eop;
      end
    end
  end

  assign i_core_rpl.rdy = crpl_rdy;
  assign o_orphan       = orphan;
  assign o_busy         = busy_q;

  core_share_arb_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (GW)
  ) u_tag_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (push),
    .i_tag       (grant_q),
    .i_pop       (pop),
    .o_tag       (head),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty),
    .o_empty_nxt (fifo_empty_nxt)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= GW'(NUM_REQ - 1);
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      busy_q  <= (state_d == ARB_FWD) || !fifo_empty_nxt;
    end
  end

`ifdef CORE_SHARE_ARB_STATS_EN
  logic [NUM_REQ-1:0][GRANT_CNT_W-1:0] grant_cnt_q;
  logic [ORPHAN_CNT_W-1:0]             orphan_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      grant_cnt_q  <= '0;
      orphan_cnt_q <= '0;
    end else begin
      if (push && grant_cnt_q[grant_q] != '1)
        grant_cnt_q[grant_q] <= grant_cnt_q[grant_q] + GRANT_CNT_W'(1);
      if (orphan && orphan_cnt_q != '1)
        orphan_cnt_q <= orphan_cnt_q + ORPHAN_CNT_W'(1);
    end
  end

  assign o_grant_cnt  = grant_cnt_q;
  assign o_orphan_cnt = orphan_cnt_q;
`endif
endmodule

// File: tb/tb_core_share_arb.sv
// Directed bench for core_share_arb: cycle-by-cycle vector table plus hand sequences for credit limit and reset.
module tb_core_share_arb;
  localparam int N = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  logic [N-1:0]       r_val, r_sop, r_eop, r_rdy;
  logic [N-1:0][63:0] r_dat;
  logic               c_rdy, c_val, c_sop, c_eop;
  logic [63:0]        c_dat;
  logic [7:0]         c_ctl;
  logic               k_val, k_sop, k_eop, k_rdy;
  logic [63:0]        k_dat;
  logic [N-1:0]       p_rdy, p_val;
  logic [N-1:0][63:0] p_dat;
  logic               orphan, busy;
`ifdef CORE_SHARE_ARB_STATS_EN
  logic [N-1:0][31:0] grant_cnt;
  logic [15:0]        orphan_cnt;
`endif

  core_share_arb_if #(.DAT_BYTS(8), .CTL_BITS(8)) req_if [N] ();
  core_share_arb_if #(.DAT_BYTS(8), .CTL_BITS(8)) rpl_if [N] ();
  core_share_arb_if #(.DAT_BYTS(8), .CTL_BITS(8)) core_if ();
  core_share_arb_if #(.DAT_BYTS(8), .CTL_BITS(8)) crpl_if ();

  for (genvar i = 0; i < N; i++) begin : g_if
    assign req_if[i].dat = r_dat[i];
    assign req_if[i].val = r_val[i];
    assign req_if[i].sop = r_sop[i];
    assign req_if[i].eop = r_eop[i];
    assign req_if[i].mod = '0;
    assign req_if[i].err = 1'b0;
    assign req_if[i].ctl = 8'(i);
    assign r_rdy[i]      = req_if[i].rdy;
    assign rpl_if[i].rdy = p_rdy[i];
    assign p_val[i]      = rpl_if[i].val;
    assign p_dat[i]      = rpl_if[i].dat;
  end

  assign core_if.rdy = c_rdy;
  assign c_val       = core_if.val;
  assign c_sop       = core_if.sop;
  assign c_eop       = core_if.eop;
  assign c_dat       = core_if.dat;
  assign c_ctl       = core_if.ctl;

  assign crpl_if.dat = k_dat;
  assign crpl_if.val = k_val;
  assign crpl_if.sop = k_sop;
  assign crpl_if.eop = k_eop;
  assign crpl_if.mod = '0;
  assign crpl_if.err = 1'b0;
  assign crpl_if.ctl = '0;
  assign k_rdy       = crpl_if.rdy;

  core_share_arb #(
    .NUM_REQ(N), .DAT_BYTS(8), .CTL_BITS(8), .MAX_OUTSTANDING(4)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req      (req_if),
    .o_core     (core_if),
    .i_core_rpl (crpl_if),
    .o_rpl      (rpl_if),
    .o_orphan   (orphan),
    .o_busy     (busy)
`ifdef CORE_SHARE_ARB_STATS_EN
    ,
    .o_grant_cnt  (grant_cnt),
    .o_orphan_cnt (orphan_cnt)
`endif
  );

  typedef struct {
    logic [1:0] rv, rs, re;
    logic       crdy, kv, ke;
    logic [1:0] prdy;
    logic       cval;
    logic [1:0] rrdy, pval;
    logic       krdy, orph, bsy;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] rv, rs, re, input logic crdy, kv, ke,
                              input logic [1:0] prdy, input logic cval, input logic [1:0] rrdy, pval,
                              input logic krdy, orph, bsy);
    vec_t v;
    v.rv = rv; v.rs = rs; v.re = re; v.crdy = crdy; v.kv = kv; v.ke = ke; v.prdy = prdy;
    v.cval = cval; v.rrdy = rrdy; v.pval = pval; v.krdy = krdy; v.orph = orph; v.bsy = bsy;
    return v;
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    r_val = '0; r_sop = '0; r_eop = '0; r_dat = '0; c_rdy = 1'b0;
    k_val = 1'b0; k_sop = 1'b0; k_eop = 1'b0; k_dat = '0; p_rdy = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Wait (bounded) for an o_core handshake and compare the word, then step past the edge.
  task automatic core_hs(input string nm, input logic [63:0] edat, input logic esop, eeop, input logic [7:0] ectl);
    bit got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (c_val && c_rdy) begin
        got = 1'b1;
        check(nm, {c_dat, c_sop, c_eop, c_ctl}, {edat, esop, eeop, ectl});
      end
    end
    if (!got) begin
      nvec++; nerr++;
      $display("FAIL %s: got no handshake expected one within 20 cycles", nm);
    end
    @(posedge clk); #1;
  endtask

  vec_t vecs[15];

  initial begin
    int nhs;
    logic [3:0] order;

    vecs[0]  = mk(2'b00, 2'b00, 2'b00, 0, 0, 0, 2'b00,  0, 2'b00, 2'b00, 0, 0, 0);
    vecs[1]  = mk(2'b01, 2'b01, 2'b00, 1, 0, 0, 2'b00,  0, 2'b00, 2'b00, 0, 0, 0);
    vecs[2]  = mk(2'b01, 2'b01, 2'b00, 1, 0, 0, 2'b00,  1, 2'b01, 2'b00, 0, 0, 1);
    vecs[3]  = mk(2'b11, 2'b10, 2'b00, 1, 0, 0, 2'b00,  1, 2'b01, 2'b00, 0, 0, 1);
    vecs[4]  = mk(2'b11, 2'b10, 2'b01, 1, 0, 0, 2'b00,  1, 2'b01, 2'b00, 0, 0, 1);
    vecs[5]  = mk(2'b10, 2'b10, 2'b00, 1, 1, 0, 2'b01,  0, 2'b00, 2'b01, 1, 0, 1);
    vecs[6]  = mk(2'b10, 2'b10, 2'b10, 0, 1, 1, 2'b00,  1, 2'b00, 2'b01, 0, 0, 1);
    vecs[7]  = mk(2'b10, 2'b10, 2'b10, 1, 1, 1, 2'b01,  1, 2'b10, 2'b01, 1, 0, 1);
    vecs[8]  = mk(2'b01, 2'b00, 2'b00, 1, 1, 1, 2'b10,  0, 2'b01, 2'b10, 1, 0, 1);
    vecs[9]  = mk(2'b00, 2'b00, 2'b00, 1, 1, 0, 2'b00,  0, 2'b00, 2'b00, 1, 1, 0);
    vecs[10] = mk(2'b11, 2'b11, 2'b00, 1, 1, 1, 2'b00,  0, 2'b00, 2'b00, 1, 1, 0);
    vecs[11] = mk(2'b11, 2'b11, 2'b11, 1, 0, 0, 2'b00,  1, 2'b01, 2'b00, 0, 0, 1);
    vecs[12] = mk(2'b10, 2'b10, 2'b10, 1, 0, 0, 2'b00,  0, 2'b00, 2'b00, 0, 0, 1);
    vecs[13] = mk(2'b10, 2'b10, 2'b10, 1, 0, 0, 2'b00,  1, 2'b10, 2'b00, 0, 0, 1);
    vecs[14] = mk(2'b00, 2'b00, 2'b00, 1, 0, 0, 2'b00,  0, 2'b00, 2'b00, 0, 0, 1);

    // Reset must hold every val/rdy/orphan low even with live inputs.
    rst = 1'b1;
    clear_inputs();
    @(posedge clk); #1;
    k_val = 1'b1; k_eop = 1'b1; r_val = 2'b11;
    @(negedge clk);
    check("in_reset", {c_val, r_rdy, p_val, k_rdy, orphan, busy}, '0);
    @(posedge clk); #1;
    clear_inputs();
    rst = 1'b0;

    r_dat[0] = 64'hA0; r_dat[1] = 64'hA1;
    for (int t = 0; t < 15; t++) begin
      @(posedge clk); #1;
      r_val = vecs[t].rv; r_sop = vecs[t].rs; r_eop = vecs[t].re; c_rdy = vecs[t].crdy;
      k_val = vecs[t].kv; k_sop = vecs[t].kv; k_eop = vecs[t].ke; p_rdy = vecs[t].prdy;
      k_dat = 64'hD0 + 64'(t);
      @(negedge clk);
      check($sformatf("vec%0d", t), {c_val, r_rdy, p_val, k_rdy, orphan, busy},
            {vecs[t].cval, vecs[t].rrdy, vecs[t].pval, vecs[t].krdy, vecs[t].orph, vecs[t].bsy});
    end

    // Two tags outstanding (0 then 1): replies route in order.
    @(posedge clk); #1;
    r_val = '0; k_val = 1'b1; k_sop = 1'b1; k_eop = 1'b1; k_dat = 64'h1111; p_rdy = 2'b11;
    @(negedge clk);
    check("rpl_first", {p_val, p_dat[0]}, {2'b01, 64'h1111});
    @(posedge clk); #1;
    k_dat = 64'h2222;
    @(negedge clk);
    check("rpl_second", {p_val, p_dat[1]}, {2'b10, 64'h2222});
    @(posedge clk); #1;
    k_val = 1'b0;
    @(negedge clk);
    check("rpl_drained", {p_val, busy}, '0);

    // Credit limit: core never replies, both requesters stream single-word packets.
    do_reset();
    r_val = 2'b11; r_sop = 2'b11; r_eop = 2'b11; c_rdy = 1'b1;
    r_dat[0] = 64'hB0; r_dat[1] = 64'hB1;
    nhs = 0; order = '0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (c_val && c_rdy) begin
        nhs++;
        order = {order[2:0], r_rdy[1]};
      end
    end
    check("credit_fwd_cnt", 128'(nhs), 128'd4);
    check("credit_alt_order", {order, c_val, busy}, {4'b0101, 1'b0, 1'b1});
    @(posedge clk); #1;
    k_val = 1'b1; k_sop = 1'b1; k_eop = 1'b1; k_dat = 64'h33; p_rdy = 2'b11;
    @(negedge clk);
    check("credit_rpl", {p_val, k_rdy}, {2'b01, 1'b1});
    @(posedge clk); #1;
    k_val = 1'b0;
    nhs = 0; order = '0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (c_val && c_rdy) begin
        nhs++;
        order = {order[2:0], r_rdy[1]};
      end
    end
    check("credit_refill", {128'(nhs), order}, {128'd1, 4'b0000});

    // Reset in the middle of a 4-word packet, then a clean packet from requester 1.
    do_reset();
    c_rdy = 1'b1;
    r_val = 2'b01; r_sop = 2'b01; r_dat[0] = 64'hC0;
    core_hs("mid_w0", 64'hC0, 1'b1, 1'b0, 8'd0);
    r_sop = 2'b00; r_dat[0] = 64'hC1;
    core_hs("mid_w1", 64'hC1, 1'b0, 1'b0, 8'd0);
    r_dat[0] = 64'hC2;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_gate", {c_val, r_rdy}, '0);
    @(posedge clk); #1;
    rst = 1'b0; r_val = '0;
    @(negedge clk);
    check("post_rst", {c_val, p_val, busy}, '0);
    @(posedge clk); #1;
    r_val = 2'b10; r_sop = 2'b10; r_eop = 2'b00; r_dat[1] = 64'hE0;
    core_hs("new_w0", 64'hE0, 1'b1, 1'b0, 8'd1);
    r_sop = 2'b00; r_eop = 2'b10; r_dat[1] = 64'hE1;
    core_hs("new_w1", 64'hE1, 1'b0, 1'b1, 8'd1);
    r_val = '0; r_eop = '0;
    @(negedge clk);
    check("new_busy", 128'(busy), 128'd1);
    @(posedge clk); #1;
    k_val = 1'b1; k_sop = 1'b1; k_eop = 1'b1; k_dat = 64'h44; p_rdy = 2'b11;
    @(negedge clk);
    check("new_rpl", {p_val, p_dat[1], orphan}, {2'b10, 64'h44, 1'b0});
    @(posedge clk); #1;
    k_val = 1'b0;
    @(negedge clk);
    check("new_idle", {p_val, busy}, '0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
